hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage RV32I core.
- It produces the stall and flush controls consumed by the F/D, D/E and E/M pipeline registers, and the forwarding selects for the execute-stage ALU operands.
- It tracks multi-cycle data-memory waits with a small FSM and a watchdog.
- It keeps saturating stall and flush event counters for performance debug.

Parameters:
- CNT_WIDTH, 32, width of the stall and flush event counters.
- MEM_TIMEOUT, 64, number of consecutive mem_busy_i cycles before mem_timeout_o latches (must be ≥2).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- rd_addr1_d_i  in  5  rs1 of the instruction in D.
- rd_addr2_d_i  in  5  rs2 of the instruction in D.
- rd_addr1_e_o  in  5  rs1 of the instruction in E.
- rd_addr2_e_o  in  5  rs2 of the instruction in E.
- wr_addr_e_i  in  5  rd of the instruction in E.
- wr_addr_m_i  in  5  rd of the instruction in M.
- wr_addr_w_i  in  5  rd of the instruction in W.
- result_src_e_i  in  1  instruction in E is a load.
- reg_wr_en_m_i  in  1  instruction in M writes the register file.
- reg_wr_en_w_i  in  1  instruction in W writes the register file.
- pc_src_e_i  in  1  branch/jump taken, resolved in E.
- mem_busy_i  in  1  data memory not ready; M must hold.
- cnt_clr_i  in  1  synchronous clear of both counters.
- stall_f_o  out  1  hold PC.
- stall_d_o  out  1  hold F/D register.
- stall_e_o  out  1  hold D/E register.
- flush_d_o  out  1  bubble F/D register.
- flush_e_o  out  1  bubble D/E register.
- forward_a_e_o  out  2  ALU operand A select: 00 = reg file, 01 = W result, 10 = M ALU result.
- forward_b_e_o  out  2  ALU operand B select, same encoding as operand A.
- state_o  out  2  FSM state: 00 = RUN, 01 = MEM_WAIT, 10 = LOAD_STALL.
- stall_cnt_o  out  CNT_WIDTH  cycles with stall_f_o = 1.
- flush_cnt_o  out  CNT_WIDTH  cycles with flush_e_o = 1.
- mem_timeout_o  out  1  sticky watchdog error.

Behaviour:
- Forwarding (combinational), operand A:
  - 10 if reg_wr_en_m_i && wr_addr_m_i != 0 && wr_addr_m_i == rd_addr1_e_o.
  - Else 01 under the same test against the W stage.
  - Else 00.
  - M has priority over W. Operand B is identical using rd_addr2_e_o.
- Load-use hazard: lu = result_src_e_i && wr_addr_e_i != 0 && (wr_addr_e_i == rd_addr1_d_i || wr_addr_e_i == rd_addr2_d_i).
- Stall/flush decision (combinational), priority high to low:
  1. mem_busy_i: stall_f, stall_d and stall_e = 1; both flushes = 0. A taken branch is deferred because E is held, so it is re-presented after busy drops.
  2. pc_src_e_i: flush_d = flush_e = 1, no stall. This squashes a concurrent load-use hazard.
  3. lu: stall_f = stall_d = 1, flush_e = 1 to insert a bubble, stall_e = 0.
  4. Otherwise all zero.
- FSM (registered, next state from the same priority):
  - Any state goes to MEM_WAIT if mem_busy_i.
  - Otherwise to LOAD_STALL if lu && !pc_src_e_i.
  - Otherwise to RUN.
  - LOAD_STALL never persists by construction: after the bubble, E holds no load matching D. Two consecutive LOAD_STALL cycles are a design error and are flagged by an assertion.
- Counters:
  - Updated at each edge: stall_cnt += stall_f_o, flush_cnt += flush_e_o.
  - Both saturate at all-ones with no wrap.
  - cnt_clr_i zeroes both and takes precedence over increment that cycle.
  - Outputs are the registered values, so they lag the event by one cycle.
- Watchdog:
  - busy_run increments at each edge with mem_busy_i = 1 and clears at each edge with it 0.
  - At an edge where mem_busy_i = 1 and busy_run == MEM_TIMEOUT-1, mem_timeout_o <= 1.
  - mem_timeout_o stays set until reset; cnt_clr_i does not clear it.
  - busy_run saturates at MEM_TIMEOUT-1.
- Reset (rst_i = 1 at an edge):
  - state = RUN, counters = 0, busy_run = 0, mem_timeout_o = 0.
  - Combinational outputs follow their inputs regardless of reset.
  - Reset mid-MEM_WAIT returns state to RUN. If mem_busy_i is still high, the next edge re-enters MEM_WAIT.

Test Plan:
- Forwarding: E rs1 = 5, rs2 = 5; M writes x5 with en = 1; W writes x5 with en = 1 -> forward_a = forward_b = 10. Drop M en -> both 01. Set M rd = 0 with en = 1 -> M is not selected.
- Load-use: result_src_e = 1, wr_addr_e = 7, rd_addr2_d = 7 -> stall_f = stall_d = flush_e = 1 for one cycle, state LOAD_STALL next cycle, stall_cnt = 1 after two edges. Repeat with wr_addr_e = 0 -> no stall.
- Branch with load-use in the same cycle -> flush_d = flush_e = 1, stall_f = 0, flush_cnt increments by 1, state RUN.
- mem_busy for 3 cycles with pc_src_e = 1 throughout -> all stalls = 1 and no flush for 3 cycles. In the 4th cycle flush_d = flush_e = 1. state sequence is MEM_WAIT ×3 then RUN.
- Watchdog with MEM_TIMEOUT = 4: busy 3 cycles, idle, busy 3 -> mem_timeout_o stays 0. Busy 4 consecutive -> mem_timeout_o = 1 after the 4th edge and stays 1 through cnt_clr_i; rst_i clears it.
- Saturation/clear with CNT_WIDTH = 3: 10 load-use stalls -> stall_cnt = 7. cnt_clr_i coincident with a stall -> stall_cnt = 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forwarding control, memory-wait FSM, watchdog and event counters for a 5-stage RV32I core
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   rd_addr1/2_d_i                rs1/rs2 of the instruction in D
//   rd_addr1/2_e_o                rs1/rs2 of the instruction in E (inputs)
//   wr_addr_e/m/w_i               rd of the instructions in E, M, W
//   result_src_e_i                E holds a load
//   reg_wr_en_m_i/w_i             M/W write the register file
//   pc_src_e_i                    taken branch/jump resolved in E
//   mem_busy_i                    data memory not ready
//   cnt_clr_i                     synchronous clear of both counters
//   stall_f/d/e_o, flush_d/e_o    pipeline register controls
//   forward_a/b_e_o               ALU operand selects: 00 reg file, 01 W, 10 M
//   state_o                       00 RUN, 01 MEM_WAIT, 10 LOAD_STALL
//   stall_cnt_o, flush_cnt_o      saturating event counters (registered)
//   mem_timeout_o                 sticky watchdog error
module hazard_ctrl #(
  parameter int CNT_WIDTH   = 32,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [4:0]           rd_addr1_d_i,
  input  logic [4:0]           rd_addr2_d_i,
  input  logic [4:0]           rd_addr1_e_o,
  input  logic [4:0]           rd_addr2_e_o,
  input  logic [4:0]           wr_addr_e_i,
  input  logic [4:0]           wr_addr_m_i,
  input  logic [4:0]           wr_addr_w_i,
  input  logic                 result_src_e_i,
  input  logic                 reg_wr_en_m_i,
  input  logic                 reg_wr_en_w_i,
  input  logic                 pc_src_e_i,
  input  logic                 mem_busy_i,
  input  logic                 cnt_clr_i,
  output logic                 stall_f_o,
  output logic                 stall_d_o,
  output logic                 stall_e_o,
  output logic                 flush_d_o,
  output logic                 flush_e_o,
  output logic [1:0]           forward_a_e_o,
  output logic [1:0]           forward_b_e_o,
  output logic [1:0]           state_o,
  output logic [CNT_WIDTH-1:0] stall_cnt_o,
  output logic [CNT_WIDTH-1:0] flush_cnt_o,
  output logic                 mem_timeout_o
);
  typedef enum logic [1:0] {
    ST_RUN        = 2'b00,
    ST_MEM_WAIT   = 2'b01,
    ST_LOAD_STALL = 2'b10
  } state_t;
  localparam int BW = $clog2(MEM_TIMEOUT);
  localparam logic [BW-1:0] RUN_MAX = BW'(MEM_TIMEOUT - 1);
  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CNT_WIDTH-1:0]   r_stall_cnt;
  logic [CNT_WIDTH-1:0]   r_flush_cnt;
  logic [BW-1:0]          r_busy_run;
  logic                   r_mem_timeout;
  logic                   w_lu;
  logic                   w_fwd_m_a;
  logic                   w_fwd_w_a;
  logic                   w_fwd_m_b;
  logic                   w_fwd_w_b;
  assign w_fwd_m_a = reg_wr_en_m_i && wr_addr_m_i != 5'd0 && wr_addr_m_i == rd_addr1_e_o;
  assign w_fwd_w_a = reg_wr_en_w_i && wr_addr_w_i != 5'd0 && wr_addr_w_i == rd_addr1_e_o;
  assign w_fwd_m_b = reg_wr_en_m_i && wr_addr_m_i != 5'd0 && wr_addr_m_i == rd_addr2_e_o;
  assign w_fwd_w_b = reg_wr_en_w_i && wr_addr_w_i != 5'd0 && wr_addr_w_i == rd_addr2_e_o;
  assign forward_a_e_o = w_fwd_m_a ? 2'b10 : w_fwd_w_a ? 2'b01 : 2'b00;
  assign forward_b_e_o = w_fwd_m_b ? 2'b10 : w_fwd_w_b ? 2'b01 : 2'b00;
  assign w_lu = result_src_e_i && wr_addr_e_i != 5'd0 &&
                (wr_addr_e_i == rd_addr1_d_i || wr_addr_e_i == rd_addr2_d_i);
  // A busy memory holds everything, deferring any taken branch; a taken branch squashes a load-use stall.
  always_comb begin
    stall_f_o   = mem_busy_i || (!pc_src_e_i && w_lu);
    stall_d_o   = mem_busy_i || (!pc_src_e_i && w_lu);
    stall_e_o   = mem_busy_i;
    flush_d_o   = !mem_busy_i && pc_src_e_i;
    flush_e_o   = !mem_busy_i && (pc_src_e_i || w_lu);
    w_state_nxt = mem_busy_i ? ST_MEM_WAIT : (w_lu && !pc_src_e_i) ? ST_LOAD_STALL : ST_RUN;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= ST_RUN;
    else r_state <= w_state_nxt;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stall_cnt   <= '0;
      r_flush_cnt   <= '0;
      r_busy_run    <= '0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_stall_cnt   <= cnt_clr_i ? '0 : r_stall_cnt + CNT_WIDTH'(stall_f_o && !(&r_stall_cnt));
      r_flush_cnt   <= cnt_clr_i ? '0 : r_flush_cnt + CNT_WIDTH'(flush_e_o && !(&r_flush_cnt));
      r_busy_run    <= !mem_busy_i ? '0 : (r_busy_run == RUN_MAX) ? r_busy_run : r_busy_run + BW'(1);
      r_mem_timeout <= r_mem_timeout || (mem_busy_i && r_busy_run == RUN_MAX);
    end
  end
  // After the inserted bubble E cannot hold a load matching D, so LOAD_STALL must never repeat.
  a_no_double_load_stall: assert property (@(posedge clk_i) disable iff (rst_i)
    !(r_state == ST_LOAD_STALL && w_state_nxt == ST_LOAD_STALL));
  assign state_o       = r_state;
  assign stall_cnt_o   = r_stall_cnt;
  assign flush_cnt_o   = r_flush_cnt;
  assign mem_timeout_o = r_mem_timeout;
endmodule
